pc_seq: RTL and testbench

- Parametrised program-counter sequencer; successor to the basic 6-bit PC.
- Adds configurable address width and reset vector, a stall input, call/return through an internal return-address stack, and optional PC-relative branching.
- Sits between the control unit (which issues one-hot sequencing commands) and instruction memory (addressed by pc_out).

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_seq_ret_stack.sv | 65 ++++++
 rtl/pc_seq.sv | 123 ++++++++++++
 tb/tb_pc_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   depth_w()  - width of a counter able to hold 0..DEPTH (stack occupancy)
//   action_e   - the single action pc_seq resolves from its commands each cycle
package pc_seq_pkg;

    function automatic int depth_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [2:0] {
        ACT_CLR,
        ACT_HOLD,
        ACT_RET,
        ACT_CALL,
        ACT_LD,
        ACT_REL,
        ACT_INC
    } action_e;

endpackage

// File: rtl/pc_seq_ret_stack.sv
// ret_stack: LIFO of return addresses for pc_seq.
// Ports:
//   clk, rst_n  - clock, async active-low reset (clears the pointer only)
//   clr         - synchronous clear of the pointer
//   push, pop   - push push_data / drop top entry (ignored when full / empty)
//   push_data   - return address to store
//   top         - current top entry (meaningless while empty)
//   depth       - number of valid entries
//   full, empty - occupancy status
module ret_stack
    import pc_seq_pkg::*;
#(
    parameter int AW    = 6,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                push_data,
    output logic [AW-1:0]                top,
    output logic [depth_w(DEPTH)-1:0]    depth,
    output logic                         full,
    output logic                         empty
);
    localparam int DW = depth_w(DEPTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] ptr_reg;
    logic [AW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;

    assign full    = (ptr_reg == DW'(DEPTH));
    assign empty   = (ptr_reg == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign wr_idx  = ptr_reg[IW-1:0];
    assign rd_idx  = IW'(ptr_reg - DW'(1));
    assign top     = mem[rd_idx];
    assign depth   = ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (clr) begin
            ptr_reg <= '0;
        end else if (do_push) begin
            ptr_reg <= ptr_reg + DW'(1);
        end else if (do_pop) begin
            ptr_reg <= ptr_reg - DW'(1);
        end
    end

    // Storage has no reset: entries above the pointer are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: parametrised program-counter sequencer with call/return stack.
// Build option: define PC_BRANCH_REL_EN to enable PC-relative branching
// (rel_br / br_offset); otherwise those ports are ignored.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   clr_pc                - synchronous clear (same state as reset)
//   stall                 - hold all state
//   ret, call, ld_pc,
//   rel_br, inc_pc        - sequencing commands, in priority order
//   jump_addr             - target for ld_pc and call
//   br_offset             - two's-complement branch offset
//   pc_out                - registered program counter
//   stk_depth             - valid return-stack entries
//   stk_ovf, stk_unf      - sticky overflow / underflow flags
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int          AW        = 6,
    parameter int          DEPTH     = 4,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_pc,
    input  logic                      stall,
    input  logic                      inc_pc,
    input  logic                      ld_pc,
    input  logic [AW-1:0]             jump_addr,
    input  logic                      call,
    input  logic                      ret,
    input  logic                      rel_br,
    input  logic [AW-1:0]             br_offset,
    output logic [AW-1:0]             pc_out,
    output logic [depth_w(DEPTH)-1:0] stk_depth,
    output logic                      stk_ovf,
    output logic                      stk_unf
);
    action_e       act;
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] pc_plus1;
    logic          ovf_reg;
    logic          unf_reg;
    logic [AW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;
    logic          push;
    logic          pop;

    // One action per cycle; lower-priority commands are dropped entirely.
    always_comb begin
        act = ACT_HOLD;
        if (clr_pc)       act = ACT_CLR;
        else if (stall)   act = ACT_HOLD;
        else if (ret)     act = ACT_RET;
        else if (call)    act = ACT_CALL;
        else if (ld_pc)   act = ACT_LD;
`ifdef PC_BRANCH_REL_EN
        else if (rel_br)  act = ACT_REL;
`endif
        else if (inc_pc)  act = ACT_INC;
    end

`ifndef PC_BRANCH_REL_EN
    logic unused_rel;
    assign unused_rel = ^{rel_br, br_offset};
`endif

    assign pc_plus1 = pc_reg + AW'(1);
    assign push     = (act == ACT_CALL) && !stk_full;
    assign pop      = (act == ACT_RET) && !stk_empty;

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (act == ACT_CLR),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top       (stk_top),
        .depth     (stk_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg  <= RESET_VEC;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            case (act)
                ACT_CLR: begin
                    pc_reg  <= RESET_VEC;
                    ovf_reg <= 1'b0;
                    unf_reg <= 1'b0;
                end
                ACT_RET: begin
                    if (stk_empty) unf_reg <= 1'b1;
                    else           pc_reg  <= stk_top;
                end
                ACT_CALL: begin
                    if (stk_full) ovf_reg <= 1'b1;
                    else          pc_reg  <= jump_addr;
                end
                ACT_LD:  pc_reg <= jump_addr;
`ifdef PC_BRANCH_REL_EN
                // Modulo-2^AW add is the same as a sign-extended offset add.
                ACT_REL: pc_reg <= pc_reg + br_offset;
`endif
                ACT_INC: pc_reg <= pc_plus1;
                default: ;
            endcase
        end
    end

    assign pc_out  = pc_reg;
    assign stk_ovf = ovf_reg;
    assign stk_unf = unf_reg;

endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;
`ifdef PC_BRANCH_REL_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif
    localparam int MODW  = 64;
    localparam int MDEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_pc = 0, stall = 0, inc_pc = 0, ld_pc = 0, call = 0, ret = 0, rel_br = 0;
    logic [5:0] jump_addr = '0, br_offset = '0;
    logic [5:0] pc_a, pc_b;
    logic [2:0] dep_a, dep_b;
    logic       ovf_a, unf_a, ovf_b, unf_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_seq #(.AW(6), .DEPTH(4), .RESET_VEC(6'h00)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr_pc(clr_pc), .stall(stall), .inc_pc(inc_pc),
        .ld_pc(ld_pc), .jump_addr(jump_addr), .call(call), .ret(ret),
        .rel_br(rel_br), .br_offset(br_offset),
        .pc_out(pc_a), .stk_depth(dep_a), .stk_ovf(ovf_a), .stk_unf(unf_a));

    pc_seq #(.AW(6), .DEPTH(4), .RESET_VEC(6'h20)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr_pc(clr_pc), .stall(stall), .inc_pc(inc_pc),
        .ld_pc(ld_pc), .jump_addr(jump_addr), .call(call), .ret(ret),
        .rel_br(rel_br), .br_offset(br_offset),
        .pc_out(pc_b), .stk_depth(dep_b), .stk_ovf(ovf_b), .stk_unf(unf_b));

    // Reference model: integer PC, array stack with explicit occupancy count.
    int m_rv  [2] = '{0, 32};
    int m_pc  [2];
    int m_dep [2];
    int m_stk [2][MDEPTH];
    bit m_ovf [2];
    bit m_unf [2];

    task automatic model_reset(input int i);
        m_pc[i] = m_rv[i]; m_dep[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    endtask

    task automatic model_step(input int i);
        if (clr_pc) model_reset(i);
        else if (stall) begin end
        else if (ret) begin
            if (m_dep[i] == 0) m_unf[i] = 1;
            else begin m_dep[i]--; m_pc[i] = m_stk[i][m_dep[i]]; end
        end
        else if (call) begin
            if (m_dep[i] == MDEPTH) m_ovf[i] = 1;
            else begin
                m_stk[i][m_dep[i]] = (m_pc[i] + 1) % MODW;
                m_dep[i]++;
                m_pc[i] = int'(jump_addr);
            end
        end
        else if (ld_pc) m_pc[i] = int'(jump_addr);
        else if (rel_br && REL_EN) m_pc[i] = (m_pc[i] + int'(br_offset)) % MODW;
        else if (inc_pc) m_pc[i] = (m_pc[i] + 1) % MODW;
    endtask

    initial begin
        model_reset(0); model_reset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin model_reset(0); model_reset(1); end
            else begin model_step(0); model_step(1); end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("pc_a",  int'(pc_a),  m_pc[0]);
            check("dep_a", int'(dep_a), m_dep[0]);
            check("ovf_a", int'(ovf_a), int'(m_ovf[0]));
            check("unf_a", int'(unf_a), int'(m_unf[0]));
            check("pc_b",  int'(pc_b),  m_pc[1]);
            check("dep_b", int'(dep_b), m_dep[1]);
            check("ovf_b", int'(ovf_b), int'(m_ovf[1]));
            check("unf_b", int'(unf_b), int'(m_unf[1]));
        end
    end

    // Drive one command for one cycle; returns at the following negedge.
    task automatic cmd(input string op, input logic [5:0] a, input logic [5:0] off);
        clr_pc = 0; stall = 0; inc_pc = 0; ld_pc = 0; call = 0; ret = 0; rel_br = 0;
        jump_addr = a; br_offset = off;
        case (op)
            "clr":      clr_pc = 1;
            "stall":    stall = 1;
            "inc":      inc_pc = 1;
            "ld":       ld_pc = 1;
            "call":     call = 1;
            "ret":      ret = 1;
            "rel":      rel_br = 1;
            "callret":  begin call = 1; ret = 1; end
            "ldinc":    begin ld_pc = 1; inc_pc = 1; end
            "clrstall": begin clr_pc = 1; stall = 1; end
            "relinc":   begin rel_br = 1; inc_pc = 1; end
            default: ;
        endcase
        @(negedge clk);
        $display("cmd %-8s a=0x%02h off=0x%02h -> pc_a=0x%02h pc_b=0x%02h dep=%0d ovf=%0b unf=%0b",
                 op, a, off, pc_a, pc_b, dep_a, ovf_a, unf_a);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_pc", int'(pc_a), 0);
        check("reset_dep", int'(dep_a), 0);
        check("reset_vec_b", int'(pc_b), 32'h20);
        rst_n = 1;

        // Increment, wrap and stall
        cmd("ld", 6'h3E, 0);     check("ld_3e", int'(pc_a), 32'h3E);
        cmd("inc", 0, 0);        check("inc_3f", int'(pc_a), 32'h3F);
        cmd("stall", 0, 0);      check("stall1", int'(pc_a), 32'h3F);
        cmd("stall", 0, 0);      check("stall2", int'(pc_a), 32'h3F);
        cmd("inc", 0, 0);        check("wrap_00", int'(pc_a), 32'h00);
        cmd("inc", 0, 0);        check("inc_01", int'(pc_a), 32'h01);

        // Nested call/return
        cmd("ld", 6'h05, 0);
        cmd("call", 6'h10, 0);   check("call1_pc", int'(pc_a), 32'h10); check("call1_dep", int'(dep_a), 1);
        cmd("inc", 0, 0);
        cmd("inc", 0, 0);
        cmd("call", 6'h30, 0);   check("call2_pc", int'(pc_a), 32'h30); check("call2_dep", int'(dep_a), 2);
        cmd("ret", 0, 0);        check("ret1_pc", int'(pc_a), 32'h13);
        cmd("ret", 0, 0);        check("ret2_pc", int'(pc_a), 32'h06); check("ret2_dep", int'(dep_a), 0);

        // Overflow / underflow
        for (int k = 1; k <= 4; k++) cmd("call", 6'(k), 0);
        check("fill_dep", int'(dep_a), 4);
        cmd("call", 6'h3A, 0);   check("ovf_pc", int'(pc_a), 32'h04); check("ovf_flag", int'(ovf_a), 1);
        check("ovf_dep", int'(dep_a), 4);
        cmd("ret", 0, 0);        check("pop_04", int'(pc_a), 32'h04);
        cmd("ret", 0, 0);        check("pop_03", int'(pc_a), 32'h03);
        cmd("ret", 0, 0);        check("pop_02", int'(pc_a), 32'h02);
        cmd("ret", 0, 0);        check("pop_07", int'(pc_a), 32'h07);
        cmd("ret", 0, 0);        check("unf_pc", int'(pc_a), 32'h07); check("unf_flag", int'(unf_a), 1);
        cmd("stall", 0, 0);      check("sticky_ovf", int'(ovf_a), 1); check("sticky_unf", int'(unf_a), 1);
        cmd("inc", 0, 0);        check("sticky_ovf2", int'(ovf_a), 1);
        cmd("clr", 0, 0);        check("clr_ovf", int'(ovf_a), 0); check("clr_unf", int'(unf_a), 0);
        check("clr_vec_b", int'(pc_b), 32'h20);

        // Priority conflicts
        cmd("call", 6'h11, 0);   check("pc_call_dep", int'(dep_a), 1);
        cmd("callret", 6'h22, 0); check("callret_pc", int'(pc_a), 32'h01); check("callret_dep", int'(dep_a), 0);
        cmd("ldinc", 6'h2A, 0);  check("ldinc_pc", int'(pc_a), 32'h2A);
        cmd("clrstall", 0, 0);   check("clrstall_a", int'(pc_a), 0); check("clrstall_b", int'(pc_b), 32'h20);

        // Relative branch (or its absence)
        cmd("ld", 6'h02, 0);
        cmd("relinc", 0, 6'h3C); check("relinc_pc", int'(pc_a), REL_EN ? 32'h3E : 32'h03);
        cmd("rel", 0, 6'h05);
        cmd("nop", 0, 0);

        // Asynchronous reset mid-call
        cmd("ld", 6'h15, 0);     check("pre_rst_pc", int'(pc_a), 32'h15);
        cmd("call", 6'h08, 0);
        #2 rst_n = 0;
        #1;
        check("async_pc_a", int'(pc_a), 0);
        check("async_dep_a", int'(dep_a), 0);
        check("async_pc_b", int'(pc_b), 32'h20);
        @(negedge clk);
        rst_n = 1;
        cmd("inc", 0, 0);        check("post_rst_inc", int'(pc_a), 1);
        cmd("nop", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
